// File: rtl/mmio_timer_gpio_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer_gpio_if
// Brief    : Core data-memory bus (read/write strobes, address, data, hit).
// Revision : 1.0 - initial release
// ============================================================================
interface mmio_timer_gpio_if #(
    parameter int RAM_DATA = 32,
    parameter int RAM_ADD  = 10
);
    logic                read;
    logic                write;
    logic [RAM_ADD-1:0]  address;
    logic [RAM_DATA-1:0] data_in;
    logic [RAM_DATA-1:0] data_out;
    logic                hit;

    modport master (
        output read, write, address, data_in,
        input  data_out, hit
    );

    modport slave (
        input  read, write, address, data_in,
        output data_out, hit
    );
endinterface
`default_nettype wire

// File: rtl/mmio_timer_gpio.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer_gpio
// Brief    : 16-word MMIO window with prescaled compare timer, GPIO out/in.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_timer_gpio #(
    parameter int                 RAM_DATA  = 32,
    parameter int                 RAM_ADD   = 10,
    parameter logic [RAM_ADD-1:0] BASE_ADDR = 10'h3F0,
    parameter int                 GPIO_W    = 8
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    mmio_timer_gpio_if.slave       bus,
    output logic                   irq,
    output logic [GPIO_W-1:0]      gpio_out,
    input  wire logic [GPIO_W-1:0] gpio_in
);
    localparam logic [3:0] c_OFF_CTRL     = 4'd0;
    localparam logic [3:0] c_OFF_COUNT    = 4'd1;
    localparam logic [3:0] c_OFF_COMPARE  = 4'd2;
    localparam logic [3:0] c_OFF_STATUS   = 4'd3;
    localparam logic [3:0] c_OFF_PRESCALE = 4'd4;
    localparam logic [3:0] c_OFF_GPIO_OUT = 4'd5;
    localparam logic [3:0] c_OFF_GPIO_IN  = 4'd6;

    logic [2:0]          r_ctrl;      // {IRQ_EN, AUTO_RELOAD, EN}
    logic [31:0]         r_count;
    logic [31:0]         r_compare;
    logic                r_match;
    logic [15:0]         r_prescale;
    logic [15:0]         r_pre_cnt;
    logic [GPIO_W-1:0]   r_gpio_out;
    logic [GPIO_W-1:0]   r_sync1;
    logic [GPIO_W-1:0]   r_sync2;

    logic                w_sel;
    logic [3:0]          w_off;
    logic                w_wr;
    logic                w_tick;
    logic                w_match_evt;
    logic [RAM_DATA-1:0] w_rdata;

    assign w_sel = (bus.address[RAM_ADD-1:4] == BASE_ADDR[RAM_ADD-1:4]);
    assign w_off = bus.address[3:0];
    assign w_wr  = bus.write & w_sel;

    assign w_tick = r_ctrl[0] & (r_pre_cnt == r_prescale);
    // A COUNT write in the tick cycle suppresses the compare entirely.
    assign w_match_evt = w_tick & ~(w_wr && w_off == c_OFF_COUNT) & (r_count == r_compare);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pre_cnt <= 16'd0;
        end else if (w_wr && (w_off == c_OFF_CTRL || w_off == c_OFF_PRESCALE)) begin
            r_pre_cnt <= 16'd0;
        end else if (r_ctrl[0]) begin
            r_pre_cnt <= w_tick ? 16'd0 : r_pre_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= 32'd0;
        end else if (w_wr && w_off == c_OFF_COUNT) begin
            r_count <= bus.data_in;
        end else if (w_tick) begin
            r_count <= (w_match_evt && r_ctrl[1]) ? 32'd0 : r_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_match <= 1'b0;
        end else if (w_match_evt) begin
            r_match <= 1'b1;
        end else if (w_wr && w_off == c_OFF_STATUS && bus.data_in[0]) begin
            r_match <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ctrl     <= 3'd0;
            r_compare  <= 32'hFFFF_FFFF;
            r_prescale <= 16'd0;
            r_gpio_out <= '0;
        end else if (w_wr) begin
            case (w_off)
                c_OFF_CTRL:     r_ctrl     <= bus.data_in[2:0];
                c_OFF_COMPARE:  r_compare  <= bus.data_in;
                c_OFF_PRESCALE: r_prescale <= bus.data_in[15:0];
                c_OFF_GPIO_OUT: r_gpio_out <= bus.data_in[GPIO_W-1:0];
                default:        ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (bus.read && w_sel) begin
            case (w_off)
                c_OFF_CTRL:     w_rdata = RAM_DATA'(r_ctrl);
                c_OFF_COUNT:    w_rdata = r_count;
                c_OFF_COMPARE:  w_rdata = r_compare;
                c_OFF_STATUS:   w_rdata = RAM_DATA'(r_match);
                c_OFF_PRESCALE: w_rdata = RAM_DATA'(r_prescale);
                c_OFF_GPIO_OUT: w_rdata = RAM_DATA'(r_gpio_out);
                c_OFF_GPIO_IN:  w_rdata = RAM_DATA'(r_sync2);
                default:        w_rdata = '0;
            endcase
        end
    end

    assign bus.data_out = w_rdata;
    assign bus.hit      = w_sel & (bus.read | bus.write);
    assign irq          = r_match & r_ctrl[2];
    assign gpio_out     = r_gpio_out;
endmodule
`default_nettype wire

// File: tb/tb_mmio_timer_gpio.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_timer_gpio
// Brief    : Vector table plus timer/GPIO sequences with a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_timer_gpio;
    localparam logic [9:0] c_BASE = 10'h3F0;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       irq;
    logic [7:0] gpio_out;
    logic [7:0] gpio_in = 8'h00;

    mmio_timer_gpio_if #(.RAM_DATA(32), .RAM_ADD(10)) bus ();

    mmio_timer_gpio #(
        .RAM_DATA (32),
        .RAM_ADD  (10),
        .BASE_ADDR(10'h3F0),
        .GPIO_W   (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .irq     (irq),
        .gpio_out(gpio_out),
        .gpio_in (gpio_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        string       name;
        bit          do_wr;
        int          off;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_hit;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [9:0] a(input int off);
        logic [9:0] o;
        o = off[9:0];
        return c_BASE + o;
    endfunction

    task automatic expect_val(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic compare_next(input logic [31:0] act);
        sb_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=%h", act);
        end else begin
            e = sbq.pop_front();
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] addr, input logic [31:0] data);
        bus.address = addr;
        bus.data_in = data;
        bus.write   = 1'b1;
        cycle();
        bus.write   = 1'b0;
    endtask

    task automatic rd(input logic [9:0] addr, input logic [31:0] exp, input string name);
        bus.address = addr;
        bus.read    = 1'b1;
        expect_val(name, exp);
        #1;
        compare_next(bus.data_out);
        bus.read    = 1'b0;
    endtask

    task automatic rd_hit(input logic [9:0] addr, input logic [31:0] exp, input bit exp_hit,
                          input string name);
        bus.address = addr;
        bus.read    = 1'b1;
        expect_val({name, "_data"}, exp);
        expect_val({name, "_hit"}, {31'b0, exp_hit});
        #1;
        compare_next(bus.data_out);
        compare_next({31'b0, bus.hit});
        bus.read    = 1'b0;
    endtask

    task automatic chk_irq(input bit exp, input string name);
        expect_val(name, {31'b0, exp});
        compare_next({31'b0, irq});
    endtask

    task automatic chk_gpio(input logic [7:0] exp, input string name);
        expect_val(name, {24'b0, exp});
        compare_next({24'b0, gpio_out});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.address = '0;
        bus.data_in = '0;

        // name, do_wr, off, wdata, exp_data, exp_hit
        vecs.push_back('{"rst_ctrl",     1'b0, 0, 32'h0, 32'h0000_0000, 1'b1});
        vecs.push_back('{"rst_count",    1'b0, 1, 32'h0, 32'h0000_0000, 1'b1});
        vecs.push_back('{"rst_compare",  1'b0, 2, 32'h0, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"rst_status",   1'b0, 3, 32'h0, 32'h0000_0000, 1'b1});
        vecs.push_back('{"rst_prescale", 1'b0, 4, 32'h0, 32'h0000_0000, 1'b1});
        vecs.push_back('{"rst_gpio_out", 1'b0, 5, 32'h0, 32'h0000_0000, 1'b1});
        vecs.push_back('{"rst_gpio_in",  1'b0, 6, 32'h0, 32'h0000_0000, 1'b1});
        vecs.push_back('{"outside_rd",   1'b0, -1, 32'h0, 32'h0000_0000, 1'b0});
        vecs.push_back('{"gpio_out_wr",  1'b1, 5, 32'h0000_01A5, 32'h0000_00A5, 1'b1});
        vecs.push_back('{"unmapped_9",   1'b1, 9, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        vecs.push_back('{"ctrl_upper",   1'b1, 0, 32'hFFFF_FFF8, 32'h0000_0000, 1'b1});
        vecs.push_back('{"prescale_lo",  1'b1, 4, 32'hABCD_1234, 32'h0000_1234, 1'b1});
        vecs.push_back('{"prescale_clr", 1'b1, 4, 32'h0000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{"compare_rw",   1'b1, 2, 32'h1234_5678, 32'h1234_5678, 1'b1});
        vecs.push_back('{"count_rw",     1'b1, 1, 32'h0000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{"outside_wr",   1'b1, 16, 32'h0000_0077, 32'h0000_0000, 1'b0});

        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();
        chk_irq(1'b0, "rst_irq");
        chk_gpio(8'h00, "rst_gpio_port");

        foreach (vecs[i]) begin
            if (vecs[i].do_wr) wr(a(vecs[i].off), vecs[i].wdata);
            rd_hit(a(vecs[i].off), vecs[i].exp_data, vecs[i].exp_hit, vecs[i].name);
            cycle();
        end
        chk_gpio(8'hA5, "gpio_port_a5");

        // Simultaneous read and write returns the pre-write value.
        bus.address = a(5);
        bus.data_in = 32'h0000_005A;
        bus.read    = 1'b1;
        bus.write   = 1'b1;
        expect_val("rw_prewrite", 32'h0000_00A5);
        #1;
        compare_next(bus.data_out);
        cycle();
        bus.write = 1'b0;
        rd(a(5), 32'h0000_005A, "rw_postwrite");
        chk_gpio(8'h5A, "gpio_port_5a");

        gpio_in = 8'h3C;
        rd(a(6), 32'h0, "gpio_in_0cyc");
        cycle();
        rd(a(6), 32'h0, "gpio_in_1cyc");
        cycle();
        rd(a(6), 32'h3C, "gpio_in_2cyc");

        // Prescaled count with auto-reload and interrupt.
        wr(a(4), 32'd3);
        wr(a(2), 32'd5);
        wr(a(0), 32'd7);
        repeat (3) cycle();
        rd(a(1), 32'd0, "pre_j3");
        cycle();
        rd(a(1), 32'd1, "pre_j4");
        repeat (19) cycle();
        rd(a(1), 32'd5, "pre_j23_count");
        rd(a(3), 32'd0, "pre_j23_status");
        chk_irq(1'b0, "pre_j23_irq");
        cycle();
        rd(a(1), 32'd0, "pre_j24_reload");
        rd(a(3), 32'd1, "pre_j24_status");
        chk_irq(1'b1, "pre_j24_irq");
        wr(a(3), 32'd0);
        rd(a(3), 32'd1, "w1c_zero_keeps");
        wr(a(3), 32'd1);
        rd(a(3), 32'd0, "w1c_one_clears");
        chk_irq(1'b0, "w1c_irq_low");
        repeat (21) cycle();
        rd(a(1), 32'd5, "pre_j47_count");
        rd(a(3), 32'd0, "pre_j47_status");
        wr(a(3), 32'd1);
        rd(a(3), 32'd1, "set_beats_w1c");
        rd(a(1), 32'd0, "pre_j48_reload");
        wr(a(0), 32'd0);

        // Free-run wrap, no reload, IRQ gated off.
        wr(a(4), 32'd0);
        wr(a(2), 32'd10);
        wr(a(1), 32'hFFFF_FFFE);
        wr(a(3), 32'd1);
        wr(a(0), 32'd1);
        rd(a(1), 32'hFFFF_FFFE, "wrap_m0");
        cycle();
        rd(a(1), 32'hFFFF_FFFF, "wrap_m1");
        rd(a(3), 32'd0, "wrap_no_match");
        cycle();
        rd(a(1), 32'd0, "wrap_m2");
        cycle();
        rd(a(1), 32'd1, "wrap_m3");
        repeat (9) cycle();
        rd(a(1), 32'd10, "wrap_m12_count");
        rd(a(3), 32'd0, "wrap_m12_status");
        cycle();
        rd(a(1), 32'd11, "wrap_m13_count");
        rd(a(3), 32'd1, "wrap_m13_status");
        chk_irq(1'b0, "wrap_irq_gated");
        wr(a(0), 32'd0);
        rd(a(1), 32'd12, "en_clear_tick");
        cycle();
        rd(a(1), 32'd12, "en_off_hold");

        // Write priority over tick; compare write uses old COMPARE.
        wr(a(3), 32'd1);
        wr(a(0), 32'd1);
        wr(a(1), 32'd100);
        rd(a(1), 32'd100, "wr_wins");
        cycle();
        rd(a(1), 32'd101, "wr_then_inc");
        wr(a(2), 32'd101);
        rd(a(1), 32'd102, "cmp_wr_count");
        rd(a(3), 32'd0, "cmp_wr_old_used");
        wr(a(0), 32'd0);
        rd(a(1), 32'd103, "final_tick");

        // Reset mid-count discards everything.
        wr(a(0), 32'd7);
        repeat (3) cycle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        rd(a(1), 32'd0, "midrst_count");
        rd(a(2), 32'hFFFF_FFFF, "midrst_compare");
        rd(a(0), 32'd0, "midrst_ctrl");
        chk_gpio(8'h00, "midrst_gpio");
        cycle();
        rd(a(1), 32'd0, "midrst_stopped");

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mmio_timer_gpio.md
# mmio_timer_gpio

Memory-mapped timer/GPIO responder on the core's data-memory bus, the slave side of the core's READ/WRITE/address/data protocol alongside the data RAM. It decodes a 16-word window of the data address space and provides a prescaled 32-bit timer with compare match, auto-reload and an interrupt flag, plus a general-purpose output register and a synchronized input port. Top level routes read data from this block instead of the RAM whenever HIT is high.

## Interface
- RAM_DATA, 32, data bus width (fixed at 32; registers are 32-bit)
- RAM_ADD, 10, word-address width of the data bus
- BASE_ADDR, 10'h3F0, base word address of the window; low 4 bits must be 0
- GPIO_W, 8, width of GPIO_OUT / GPIO_IN (1..32)

- CLK  input  1  clock, all state on rising edge
- RESET_N  input  1  synchronous reset, active low
- READ  input  1  core read strobe
- WRITE  input  1  core write strobe
- ADDRESS  input  RAM_ADD  word address from core
- DATA_IN  input  RAM_DATA  write data from core
- DATA_OUT  output  RAM_DATA  read data to core
- HIT  output  1  access falls inside the window
- IRQ  output  1  timer interrupt request
- GPIO_OUT  output  GPIO_W  general-purpose outputs
- GPIO_IN  input  GPIO_W  asynchronous general-purpose inputs

## Operation
- Decode: SEL = ADDRESS[RAM_ADD-1:4] == BASE_ADDR[RAM_ADD-1:4]; HIT = SEL & (READ | WRITE); offset = ADDRESS[3:0].
- Register map (offset: name, access):
  - 0 CTRL RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; others read 0.
  - 1 COUNT RW: 32-bit timer value.
  - 2 COMPARE RW: 32-bit match value.
  - 3 STATUS: bit0 MATCH; write 1 clears, write 0 no effect.
  - 4 PRESCALE RW: bits[15:0]; others read 0.
  - 5 GPIO_OUT RW: bits[GPIO_W-1:0].
  - 6 GPIO_IN RO: 2-flop synchronized GPIO_IN, zero-extended.
  - 7..15: read 0, writes ignored.
- Writes: when WRITE & SEL, register at offset updated at next edge. READ & WRITE together: write performed, DATA_OUT shows pre-write value.
- Reads: DATA_OUT combinational from registers when READ & SEL, else 32'h0. Reads have no side effects.
- Prescaler: 16-bit PRE_CNT, runs only while EN=1. TICK = EN & (PRE_CNT == PRESCALE); on TICK PRE_CNT <= 0, else PRE_CNT+1. PRESCALE=0 gives TICK every cycle. Writing PRESCALE or CTRL clears PRE_CNT to 0. EN=0 holds PRE_CNT and COUNT.
- Counter on TICK: if COUNT == COMPARE then MATCH <= 1 and COUNT <= AUTO_RELOAD ? 0 : COUNT+1; else COUNT <= COUNT+1. Wrap 32'hFFFFFFFF -> 0 silently.
- IRQ = MATCH & IRQ_EN (combinational from registers).

## Timing
- Reset (RESET_N=0 at edge): CTRL, COUNT, STATUS, PRESCALE, GPIO_OUT, PRE_CNT, sync flops all 0; COMPARE = 32'hFFFFFFFF; hence IRQ=0, GPIO_OUT=0, DATA_OUT=0 when not reading. Reset mid-count discards all state.
- Write latency: register visible on DATA_OUT the cycle after the write edge.
- GPIO_IN to offset 6: 2-cycle synchronizer latency.
- With EN set at edge N and PRESCALE=P, first TICK in cycle N+P (COUNT increments at edge N+P+1).
- Simultaneous events:
  - COUNT write and TICK same cycle: write wins, no match evaluation that cycle.
  - MATCH set and STATUS W1C same cycle: set wins (MATCH=1).
  - COMPARE write and TICK same cycle: comparison uses old COMPARE.
  - CTRL write clearing EN on a TICK cycle: tick still applied this edge.

## Test plan
- Reset: hold RESET_N=0 two cycles, read offsets 0..6 with BASE_ADDR=10'h3F0 -> 0,0,FFFFFFFF,0,0,0,0; IRQ=0; read 10'h3EF -> HIT=0, DATA_OUT=0.
- Prescaled count: PRESCALE=3, COMPARE=5, CTRL=3'b111 -> COUNT increments every 4 cycles, MATCH and IRQ rise on the edge COUNT goes 5->0; next matches every 24 cycles.
- Free-run wrap: CTRL=1, PRESCALE=0, COUNT=FFFFFFFE, COMPARE=10 -> COUNT reads FFFFFFFF then 0 then 1, MATCH stays 0 until COUNT reaches 10 -> MATCH=1, COUNT=11 (no reload).
- W1C and collision: MATCH=1, write STATUS=0 -> stays 1; write 1 -> clears; write 1 in the same cycle a new match occurs -> MATCH=1.
- Write priority: TICK every cycle, write COUNT=100 -> next read 100, increments to 101 the following cycle.
- GPIO: write offset 5 = 32'h1A5 (GPIO_W=8) -> GPIO_OUT=8'hA5, read back 32'hA5; drive GPIO_IN=8'h3C -> offset 6 reads 32'h3C two cycles later; unmapped offset 9 write then read -> 0.
